// File: rtl/cdb_pkg.sv
// cdb_pkg: shared widths, CDB entry type and grant-pick helpers for the CDB arbiter.
package cdb_pkg;
  localparam int ROB_POS_W = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  typedef struct packed {
    logic [ROB_POS_W-1:0] rob_pos;
    logic [DATA_W-1:0]    val;
    logic                 jump;
    logic [ADDR_W-1:0]    pc;
  } cdb_entry_t;
  // Scanning from the far end lets the nearest index after last win.
  function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] last, input int n);
    int idx;
    rr_pick = last;
    for (int k = n; k >= 1; k--) begin
      idx = (int'(last) + k) % n;
      if (mask[2'(idx)]) rr_pick = 2'(idx);
    end
  endfunction
  function automatic logic [1:0] fixed_pick(input logic [3:0] mask);
    fixed_pick = '0;
    for (int k = 3; k >= 0; k--) if (mask[2'(k)]) fixed_pick = 2'(k);
  endfunction
endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo: 2-entry per-producer result queue with flush and same-cycle push/pop.
module cdb_src_fifo #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic hd, tl;
  // An empty queue exposes the incoming entry so it can be granted the same cycle.
  assign head = (count == 2'd0) ? din : mem[hd];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      hd <= 1'b0;
      tl <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[tl] <= din;
        tl <= ~tl;
      end
      if (pop) hd <= ~hd;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB arbiter over per-producer queues; CDB_FIXED_PRIO_EN selects fixed priority.
module cdb_arbiter #(
  parameter int N_SRC = 2,
  parameter int ROB_POS_W = cdb_pkg::ROB_POS_W,
  parameter int DATA_W = cdb_pkg::DATA_W,
  parameter int ADDR_W = cdb_pkg::ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       rollback,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic [N_SRC*ROB_POS_W-1:0] src_rob_pos,
  input  logic [N_SRC*DATA_W-1:0]    src_val,
  input  logic [N_SRC-1:0]           src_jump,
  input  logic [N_SRC*ADDR_W-1:0]    src_pc,
  output logic [N_SRC-1:0]           src_ready,
  output logic                       cdb_valid,
  output logic [1:0]                 cdb_src,
  output logic [ROB_POS_W-1:0]       cdb_rob_pos,
  output logic [DATA_W-1:0]          cdb_val,
  output logic                       cdb_jump,
  output logic [ADDR_W-1:0]          cdb_pc
);
  import cdb_pkg::*;
  typedef struct packed {
    logic [ROB_POS_W-1:0] rob_pos;
    logic [DATA_W-1:0]    val;
    logic                 jump;
    logic [ADDR_W-1:0]    pc;
  } entry_t;
  localparam int W = $bits(entry_t);
  entry_t in_e [N_SRC];
  entry_t head_e [N_SRC];
  logic [1:0] cnt [N_SRC];
  logic [N_SRC-1:0] push, pop, busy;
  logic go, flush;
  logic [1:0] g;
  entry_t sel;
  assign flush = rdy & rollback;
  assign go = |busy;
`ifdef CDB_FIXED_PRIO_EN
  assign g = fixed_pick(4'(busy));
`else
  logic [1:0] last;
  assign g = rr_pick(4'(busy), last, N_SRC);
  always_ff @(posedge clk) begin
    if (rst) last <= 2'(N_SRC - 1);
    else if (go) last <= g;
  end
`endif
  for (genvar i = 0; i < N_SRC; i++) begin : q
    assign in_e[i] = '{rob_pos: src_rob_pos[i*ROB_POS_W +: ROB_POS_W],
                       val: src_val[i*DATA_W +: DATA_W],
                       jump: src_jump[i],
                       pc: src_pc[i*ADDR_W +: ADDR_W]};
    assign src_ready[i] = rdy & (cnt[i] != 2'd2);
    assign push[i] = src_valid[i] & src_ready[i] & !rollback;
    assign busy[i] = rdy & !rollback & (push[i] | (cnt[i] != 2'd0));
    assign pop[i] = go & (g == 2'(i));
    cdb_src_fifo #(.W(W)) u_fifo (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .push(push[i]),
      .pop(pop[i]),
      .din(in_e[i]),
      .head(head_e[i]),
      .count(cnt[i])
    );
  end
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_SRC; i++) sel = (g == 2'(i)) ? head_e[i] : sel;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_src <= 2'd0;
      cdb_rob_pos <= '0;
      cdb_val <= '0;
      cdb_jump <= 1'b0;
      cdb_pc <= '0;
    end else if (rdy) begin
      cdb_valid <= go;
      if (go) begin
        cdb_src <= g;
        cdb_rob_pos <= sel.rob_pos;
        cdb_val <= sel.val;
        cdb_jump <= sel.jump;
        cdb_pc <= sel.pc;
      end
    end
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) result broadcast between N result producers: ALU(s), LSB, and future units.
- Each producer pushes results into a private 2-entry queue. A round-robin arbiter pops one result per cycle onto a registered CDB.
- The CDB drives the RS, LSB, ROB and Decoder wake-up inputs.
- Sits between the execution units and all CDB consumers. Rollback flushes every in-flight result.

Parameters:
- N_SRC, 2, number of producers (2..4); source 0 = ALU, source 1 = LSB
- ROB_POS_W, 4, ROB index width
- DATA_W, 32, result value width
- ADDR_W, 32, branch-target PC width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low = freeze
- rollback  in  1  ROB misprediction flush
- src_valid  in  N_SRC  per-source push request
- src_rob_pos  in  N_SRC*ROB_POS_W  flattened; source i at bits [i*ROB_POS_W +: ROB_POS_W]
- src_val  in  N_SRC*DATA_W  flattened result values
- src_jump  in  N_SRC  branch-taken flag
- src_pc  in  N_SRC*ADDR_W  flattened resolved target PC
- src_ready  out  N_SRC  queue can accept a push this cycle
- cdb_valid  out  1  broadcast valid
- cdb_src  out  2  index of the granted source
- cdb_rob_pos  out  ROB_POS_W  broadcast ROB index
- cdb_val  out  DATA_W  broadcast value
- cdb_jump  out  1  broadcast jump flag
- cdb_pc  out  ADDR_W  broadcast PC

Behaviour:
- Reset (rst high at a clk edge):
  - All queues empty; cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc = 0.
  - Round-robin pointer last = N_SRC-1, so source 0 has first priority.
- src_ready[i] = rdy & (count_i < 2). It is combinational from registers only and never depends on src_valid.
- Push: src_valid[i] & src_ready[i] & !rollback writes the entry at the tail of queue i.
- Grant each cycle (rdy high, no rollback):
  - Scan indices last+1 .. last+N_SRC mod N_SRC and pick the first non-empty queue g.
  - Pop its head into the cdb_* registers, set cdb_valid=1 next cycle, cdb_src=g, last=g.
  - No non-empty queue: cdb_valid=0 next cycle; data registers hold; last unchanged.
- Latency: a result pushed at edge t is visible on the CDB at t+1 at the earliest, because the queue head is visible the same cycle as the push.
  - Bypass: an empty queue with a push and a grant in the same cycle forwards the pushed entry directly.
- Queue rules:
  - Push and pop of the same queue in one cycle: count unchanged, FIFO order preserved.
  - Full queue with a pop: src_ready is still 0 that cycle, so there is no same-cycle refill.
  - Wrap-around uses a 1-bit head/tail index per queue.
- cdb_valid is high for exactly one cycle per popped entry. At most one entry is broadcast per cycle; ordering is preserved per source.
- Rollback (rdy high):
  - Queues cleared; that cycle's pushes dropped; cdb_valid=0 next cycle; last retained.
  - A rollback coinciding with a non-empty queue produces no broadcast.
- rdy low:
  - All state and outputs hold; no push, no pop.
  - rollback and src_valid are ignored (rst still acts).
- Starvation bound: a non-empty queue is granted within N_SRC cycles.

Optional Feature:
- Macro: CDB_FIXED_PRIO_EN
- Defined: fixed priority. The lowest-index non-empty queue always wins, last is unused, and the starvation bound no longer applies; producers must tolerate stalls via src_ready.
- Undefined: round-robin as above.

Decomposition:
- Shared package cdb_pkg:
  - width constants ROB_POS_W, DATA_W, ADDR_W
  - typedef cdb_entry_t {rob_pos, val, jump, pc}
  - function rr_pick(mask, last) returning the grant index
- Sub-module cdb_src_fifo: 2-entry synchronous FIFO with count, flush and same-cycle push/pop, instantiated N_SRC times.
- The arbiter and output register live in the top.

Test Plan:
- Reset, then ALU pushes {rob 3, val 0x11}: src_ready=2'b11 after reset; the next cycle shows cdb_valid=1, cdb_src=0, cdb_rob_pos=3, cdb_val=0x11; the cycle after shows cdb_valid=0.
- ALU and LSB push every cycle for 6 cycles: cdb_src alternates 0,1,0,1…; each queue reaches count 2; src_ready drops and recovers; no entry is lost or duplicated; per-source rob_pos order is preserved.
- LSB pushes {rob 5, val 0xDEAD, jump 1, pc 0x1000} while the ALU is idle: broadcast the next cycle with exact fields; last becomes 1.
- Both queues full, then rollback pulsed with a simultaneous ALU push: the cycle after shows cdb_valid=0; all queues empty; src_ready=2'b11; the pushed entry never appears.
- rdy held low for 3 cycles with a queued entry: cdb outputs frozen and src_ready=0; when rdy rises the entry broadcasts in the next cycle.
- CDB_FIXED_PRIO_EN defined, both sources streaming: cdb_src stays 0 while queue 0 is non-empty; LSB broadcasts only in ALU gaps.
